// File: rtl/vga_pkg.sv
// Shared definitions for the bouncing-box video block: colour widths,
// direction encoding and the four-entry colour palette.
package vga_pkg;

   localparam int RED_W   = 3;
   localparam int GREEN_W = 3;
   localparam int BLUE_W  = 2;

   typedef enum logic {
      DIR_INC = 1'b0,
      DIR_DEC = 1'b1
   } dir_t;

   typedef struct packed {
      logic [RED_W-1:0]   red;
      logic [GREEN_W-1:0] green;
      logic [BLUE_W-1:0]  blue;
   } rgb_t;

   localparam rgb_t PAL_RED   = '{red: 3'b111, green: 3'b000, blue: 2'b00};
   localparam rgb_t PAL_GREEN = '{red: 3'b000, green: 3'b111, blue: 2'b00};
   localparam rgb_t PAL_BLUE  = '{red: 3'b000, green: 3'b000, blue: 2'b11};
   localparam rgb_t PAL_WHITE = '{red: 3'b111, green: 3'b111, blue: 2'b11};
   localparam rgb_t PAL_BLACK = '{red: 3'b000, green: 3'b000, blue: 2'b00};

   // Map the 2-bit colour index onto its palette entry
   function automatic rgb_t palette(input logic [1:0] idx);
      rgb_t c;
      case (idx)
         2'd0:    c = PAL_RED;
         2'd1:    c = PAL_GREEN;
         2'd2:    c = PAL_BLUE;
         default: c = PAL_WHITE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/bounce_axis.sv
// One axis of box motion: position, travel direction and a one-cycle
// bounce flag raised whenever the box hits an edge and turns around.
module bounce_axis
   import vga_pkg::*;
#(
   parameter int EXTENT = 640,
   parameter int SIZE   = 41,
   parameter int STEP   = 2,
   parameter int START  = 300
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        step_en,
   output logic [10:0] pos,
   output dir_t        dir,
   output logic        bounce
);

   localparam logic [11:0] LIMIT    = 12'(EXTENT - 1);
   localparam logic [11:0] SPAN     = 12'(SIZE - 1 + STEP);
   localparam logic [10:0] STEP_V   = 11'(STEP);
   localparam logic [10:0] FAR_STOP = 11'(EXTENT - SIZE);
   localparam logic [10:0] START_V  = 11'(START);

   logic [11:0] far_edge;

   // Far edge after a forward step, kept 12 bits wide so it cannot wrap
   always_comb begin
      far_edge = {1'b0, pos} + SPAN;
   end

   // Advance one step per enabled update, clamping and reversing at either edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pos    <= START_V;
         dir    <= DIR_INC;
         bounce <= 1'b0;
      end else begin
         bounce <= 1'b0;
         if (step_en) begin
            if (dir == DIR_INC) begin
               if (far_edge > LIMIT) begin
                  pos    <= FAR_STOP;
                  dir    <= DIR_DEC;
                  bounce <= 1'b1;
               end else begin
                  pos <= pos + STEP_V;
               end
            end else begin
               if (pos < STEP_V) begin
                  pos    <= 11'd0;
                  dir    <= DIR_INC;
                  bounce <= 1'b1;
               end else begin
                  pos <= pos - STEP_V;
               end
            end
         end
      end
   end

endmodule

// File: rtl/vga_bounce_box.sv
// Draws a square box that moves a few pixels per frame and bounces off the
// screen edges, changing colour on every bounce. Pixel output is registered
// with one clock of latency relative to hcount/vcount/blank.
module vga_bounce_box
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int BOX_SIZE = 41,
   parameter int STEP     = 2,
   parameter int X0       = 300,
   parameter int Y0       = 220
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [10:0]        hcount,
   input  logic [10:0]        vcount,
   input  logic               blank,
   input  logic               vblank,
   input  logic               pause,
   output logic [RED_W-1:0]   red,
   output logic [GREEN_W-1:0] green,
   output logic [BLUE_W-1:0]  blue,
   output logic               bounce
);

   localparam logic [11:0] BOX_LAST = 12'(BOX_SIZE - 1);

   logic        vblank_d;
   logic        update;
   logic        step_en;
   logic [10:0] x_pos;
   logic [10:0] y_pos;
   dir_t        dir_x;
   dir_t        dir_y;
   logic        bounce_x;
   logic        bounce_y;
   logic [1:0]  colour;
   logic        hit;
   rgb_t        pixel;

   assign step_en = update & ~pause;
   assign bounce  = bounce_x | bounce_y;

   bounce_axis #(
      .EXTENT (H_ACTIVE),
      .SIZE   (BOX_SIZE),
      .STEP   (STEP),
      .START  (X0)
   ) u_axis_x (
      .clk     (clk),
      .rst     (rst),
      .step_en (step_en),
      .pos     (x_pos),
      .dir     (dir_x),
      .bounce  (bounce_x)
   );

   bounce_axis #(
      .EXTENT (V_ACTIVE),
      .SIZE   (BOX_SIZE),
      .STEP   (STEP),
      .START  (Y0)
   ) u_axis_y (
      .clk     (clk),
      .rst     (rst),
      .step_en (step_en),
      .pos     (y_pos),
      .dir     (dir_y),
      .bounce  (bounce_y)
   );

   // Register the vblank rising edge into a single update strobe per frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vblank_d <= 1'b1;
         update   <= 1'b0;
      end else begin
         vblank_d <= vblank;
         update   <= vblank & ~vblank_d;
      end
   end

   // Inclusive box hit test with 12-bit far edges so the sums never wrap
   always_comb begin
      hit = (hcount >= x_pos) && ({1'b0, hcount} <= ({1'b0, x_pos} + BOX_LAST)) &&
            (vcount >= y_pos) && ({1'b0, vcount} <= ({1'b0, y_pos} + BOX_LAST));
   end

   // Advance the colour once per bounce event, even when both axes bounce
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         colour <= 2'd0;
      end else if (bounce) begin
         colour <= colour + 2'd1;
      end
   end

   // Registered pixel colour: black while blanked or outside the box
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pixel <= PAL_BLACK;
      end else if (blank) begin
         pixel <= PAL_BLACK;
      end else if (hit) begin
         pixel <= palette(colour);
      end else begin
         pixel <= PAL_BLACK;
      end
   end

   assign red   = pixel.red;
   assign green = pixel.green;
   assign blue  = pixel.blue;

endmodule

// File: tb/tb_vga_bounce_box.sv
// Directed bench for the bouncing box: three instances share the same video
// timing inputs; A uses default parameters, B starts next to the bottom-right
// corner, C uses a square 640x640 field so both axes reach zero together.
module tb_vga_bounce_box;
   import vga_pkg::*;

   logic        clk;
   logic        rst;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        blank;
   logic        vblank;
   logic        pause;

   logic [2:0]  redA, greenA, redB, greenB, redC, greenC;
   logic [1:0]  blueA, blueB, blueC;
   logic        bounceA, bounceB, bounceC;

   int errorCount = 0;
   int checkCount = 0;
   int pulsesA = 0;
   int pulsesB = 0;
   int pulsesC = 0;
   int snapA;
   int snapB;
   int snapC;
   logic [7:0] pixA, pixB, pixC;

   vga_bounce_box dutA (
      .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .blank(blank),
      .vblank(vblank), .pause(pause), .red(redA), .green(greenA), .blue(blueA),
      .bounce(bounceA)
   );

   vga_bounce_box #(.X0(598), .Y0(438)) dutB (
      .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .blank(blank),
      .vblank(vblank), .pause(pause), .red(redB), .green(greenB), .blue(blueB),
      .bounce(bounceB)
   );

   vga_bounce_box #(.H_ACTIVE(640), .V_ACTIVE(640), .X0(598), .Y0(598)) dutC (
      .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .blank(blank),
      .vblank(vblank), .pause(pause), .red(redC), .green(greenC), .blue(blueC),
      .bounce(bounceC)
   );

   assign pixA = {redA, greenA, blueA};
   assign pixB = {redB, greenB, blueB};
   assign pixC = {redC, greenC, blueC};

   // Free-running pixel clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Tally bounce pulses, one per high cycle, for each instance
   always @(negedge clk) begin
      if (bounceA) pulsesA++;
      if (bounceB) pulsesB++;
      if (bounceC) pulsesC++;
   end

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one pixel coordinate and wait for the registered result
   task automatic applyStimulus(input logic [10:0] h, input logic [10:0] v, input logic b);
      @(negedge clk);
      hcount = h;
      vcount = v;
      blank  = b;
      @(posedge clk);
      #1;
   endtask

   // One frame's vertical blanking interval: a single vblank rising edge
   task automatic runFrame();
      @(negedge clk);
      vblank = 1'b1;
      repeat (2) @(negedge clk);
      vblank = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst    = 1'b0;
      hcount = 11'd0;
      vcount = 11'd0;
      blank  = 1'b1;
      vblank = 1'b0;
      pause  = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_pixel", pixA, 8'h00);
      checkOutput("reset_bounce", bounceA, 1'b0);
      rst = 1'b1;

      // Box at (300,220) size 41 covers columns 300..340
      applyStimulus(11'd300, 11'd220, 1'b0);
      checkOutput("hit_topleft_red", pixA, 8'b111_000_00);
      applyStimulus(11'd340, 11'd260, 1'b0);
      checkOutput("hit_bottomright_red", pixA, 8'b111_000_00);
      applyStimulus(11'd341, 11'd220, 1'b0);
      checkOutput("miss_right_edge", pixA, 8'h00);
      applyStimulus(11'd299, 11'd220, 1'b0);
      checkOutput("miss_left_edge", pixA, 8'h00);
      applyStimulus(11'd300, 11'd261, 1'b0);
      checkOutput("miss_below", pixA, 8'h00);
      applyStimulus(11'd310, 11'd230, 1'b1);
      checkOutput("blank_forces_black", pixA, 8'h00);

      // One frame update: A moves to (302,222); B and C bounce on both axes at once
      snapA = pulsesA;
      snapB = pulsesB;
      snapC = pulsesC;
      runFrame();
      checkOutput("A_x_after_frame", dutA.x_pos, 11'd302);
      checkOutput("A_y_after_frame", dutA.y_pos, 11'd222);
      checkOutput("A_no_bounce", pulsesA - snapA, 0);
      checkOutput("B_x_clamped", dutB.x_pos, 11'd599);
      checkOutput("B_y_clamped", dutB.y_pos, 11'd439);
      checkOutput("B_dir_x_left", dutB.dir_x, DIR_DEC);
      checkOutput("B_dir_y_up", dutB.dir_y, DIR_DEC);
      checkOutput("B_single_pulse", pulsesB - snapB, 1);
      applyStimulus(11'd302, 11'd222, 1'b0);
      checkOutput("A_pix_moved_red", pixA, 8'b111_000_00);
      applyStimulus(11'd301, 11'd222, 1'b0);
      checkOutput("A_pix_old_col_black", pixA, 8'h00);
      applyStimulus(11'd639, 11'd479, 1'b0);
      checkOutput("B_pix_green", pixB, 8'b000_111_00);

      // C walks from 599 down to 1 in 299 frames, then clamps to 0 on the next
      for (int i = 0; i < 300; i++) runFrame();
      checkOutput("C_x_zero", dutC.x_pos, 11'd0);
      checkOutput("C_y_zero", dutC.y_pos, 11'd0);
      checkOutput("C_dir_x_right", dutC.dir_x, DIR_INC);
      checkOutput("C_dir_y_down", dutC.dir_y, DIR_INC);
      checkOutput("C_two_pulses", pulsesC - snapC, 2);
      applyStimulus(11'd0, 11'd0, 1'b0);
      checkOutput("C_pix_blue", pixC, 8'b000_000_11);

      // Asynchronous reset in the middle of a frame takes effect at once
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("midframe_rst_x", dutA.x_pos, 11'd300);
      checkOutput("midframe_rst_y", dutA.y_pos, 11'd220);
      checkOutput("midframe_rst_pix", pixA, 8'h00);

      // Releasing reset while vblank is already high must not trigger an update
      vblank = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("no_update_rst_in_vblank", dutA.x_pos, 11'd300);
      vblank = 1'b0;
      repeat (2) @(negedge clk);
      vblank = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("first_update_after_rst", dutA.x_pos, 11'd302);
      vblank = 1'b0;
      @(negedge clk);

      // Pause freezes motion across several frames while drawing continues
      pause = 1'b1;
      snapA = pulsesA;
      for (int i = 0; i < 5; i++) runFrame();
      checkOutput("pause_x_frozen", dutA.x_pos, 11'd302);
      checkOutput("pause_y_frozen", dutA.y_pos, 11'd222);
      checkOutput("pause_no_bounce", pulsesA - snapA, 0);
      applyStimulus(11'd302, 11'd222, 1'b0);
      checkOutput("pause_pix_red", pixA, 8'b111_000_00);
      pause = 1'b0;
      runFrame();
      checkOutput("resume_x", dutA.x_pos, 11'd304);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
